mc_datapath: RTL and testbench

Multicycle MIPS-subset core: datapath plus its own control FSM. One unified instruction/data memory port with a ready handshake, so memories with wait states can be attached. It replaces the single-cycle datapath/controller pair where a shared, variable-latency memory is required. Executes the team's existing instruction subset plus `bne`, `andi` and `ori`. Adds a retire pulse and an illegal-instruction halt.

---
 rtl/mc_datapath_if.sv | 19 +
 rtl/mc_datapath.sv | 153 +++++++++++++++
 tb/tb_mc_datapath.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_datapath_if.sv
// Unified instruction/data memory port with a ready handshake.
interface mc_datapath_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mc_datapath.sv
// Multicycle MIPS-subset core: datapath and control FSM sharing one memory port.
// Supports add/sub/and/or/nor/slt/sll/srl, addi/andi/ori, lw/sw, beq/bne, j.
module mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  mc_datapath_if.master       mem,
  output logic [31:0]         pc,
  output logic                retire,
  output logic                halted
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTEXEC, S_IEXEC, S_REGWB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t      r_state, w_next;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_aluout, r_mdr;
  logic [31:0] r_rf [32];

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt, w_dest;
  logic [31:0] w_sext, w_zext, w_ea, w_alu_r, w_alu_i;
  logic        w_bad_funct, w_taken;

  assign w_op    = r_ir[31:26];
  assign w_rs    = r_ir[25:21];
  assign w_rt    = r_ir[20:16];
  assign w_rd    = r_ir[15:11];
  assign w_shamt = r_ir[10:6];
  assign w_funct = r_ir[5:0];
  assign w_sext  = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_zext  = {16'h0000, r_ir[15:0]};
  assign w_ea    = r_a + w_sext;
  assign w_dest  = (w_op == OP_RTYPE) ? w_rd : w_rt;
  assign w_taken = (w_op == OP_BEQ) ? (r_a == r_b) : (r_a != r_b);

  always_comb begin
    w_alu_r     = '0;
    w_bad_funct = 1'b0;
    case (w_funct)
      6'h20:   w_alu_r = r_a + r_b;
      6'h22:   w_alu_r = r_a - r_b;
      6'h24:   w_alu_r = r_a & r_b;
      6'h25:   w_alu_r = r_a | r_b;
      6'h27:   w_alu_r = ~(r_a | r_b);
      6'h2A:   w_alu_r = {31'b0, $signed(r_a) < $signed(r_b)};
      6'h00:   w_alu_r = r_b << w_shamt;
      6'h02:   w_alu_r = r_b >> w_shamt;
      default: w_bad_funct = 1'b1;
    endcase
  end

  always_comb begin
    w_alu_i = '0;
    case (w_op)
      OP_ADDI: w_alu_i = r_a + w_sext;
      OP_ANDI: w_alu_i = r_a & w_zext;
      default: w_alu_i = r_a | w_zext;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem.mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_RTYPE:                  w_next = S_RTEXEC;
          OP_LW, OP_SW:              w_next = S_MEMADR;
          OP_BEQ, OP_BNE:            w_next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:  w_next = S_IEXEC;
          OP_J:                      w_next = S_JUMP;
          default:                   w_next = S_HALT;
        endcase
      end
      S_RTEXEC: w_next = w_bad_funct ? S_HALT : S_REGWB;
      S_IEXEC:  w_next = S_REGWB;
      S_MEMADR: begin
        if (w_ea[1:0] != 2'b00)  w_next = S_HALT;
        else if (w_op == OP_LW)  w_next = S_MEMRD;
        else                     w_next = S_MEMWR;
      end
      S_MEMRD:  if (mem.mem_ready) w_next = S_MEMWB;
      S_MEMWR:  if (mem.mem_ready) w_next = S_FETCH;
      S_REGWB, S_MEMWB, S_BRANCH, S_JUMP: w_next = S_FETCH;
      default:  w_next = S_HALT;
    endcase
  end

  // mem_req is gated by reset so an in-flight access is dropped the instant reset asserts.
  always_comb begin
    mem.mem_req   = reset & ((r_state == S_FETCH) | (r_state == S_MEMRD) | (r_state == S_MEMWR));
    mem.mem_we    = reset & (r_state == S_MEMWR);
    mem.mem_addr  = ((r_state == S_MEMRD) || (r_state == S_MEMWR)) ? r_aluout : r_pc;
    mem.mem_wdata = (r_state == S_MEMWR) ? r_b : '0;
    retire        = (r_state == S_REGWB) | (r_state == S_MEMWB) | (r_state == S_BRANCH) |
                    (r_state == S_JUMP)  | ((r_state == S_MEMWR) & mem.mem_ready);
    halted        = (r_state == S_HALT);
    pc            = r_pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
      for (int unsigned i = 0; i < 32; i++) r_rf[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (mem.mem_ready) begin
          r_ir <= mem.mem_rdata;
          r_pc <= r_pc + 32'd4;
        end
        S_DECODE: begin
          r_a      <= r_rf[w_rs];
          r_b      <= r_rf[w_rt];
          r_aluout <= r_pc + {w_sext[29:0], 2'b00};
        end
        S_RTEXEC: r_aluout <= w_alu_r;
        S_IEXEC:  r_aluout <= w_alu_i;
        S_MEMADR: r_aluout <= w_ea;
        S_REGWB:  if (w_dest != 5'd0) r_rf[w_dest] <= r_aluout;
        S_MEMRD:  if (mem.mem_ready) r_mdr <= mem.mem_rdata;
        S_MEMWB:  if (w_rt != 5'd0) r_rf[w_rt] <= r_mdr;
        S_BRANCH: if (w_taken) r_pc <= r_aluout;
        S_JUMP:   r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
// Directed-program bench for mc_datapath with a wait-state-capable memory model.
module tb_mc_datapath;
  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        retire, halted;

  mc_datapath_if bus ();

  mc_datapath #(.RESET_PC(32'h0000_0100)) dut (
    .clk    (clk),
    .reset  (reset),
    .mem    (bus.master),
    .pc     (pc),
    .retire (retire),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Code lives at 0x100 and above in rom; data words 0x00..0xFC live in dmem.
  logic [31:0] rom  [0:1023];
  logic [31:0] dmem [0:63];
  logic [31:0] dfill;
  int unsigned wcnt, wait_n;
  bit          hold_wr;
  int          n_acc, n_wr;

  assign bus.mem_ready = bus.mem_req && (wcnt >= wait_n) && !(hold_wr && bus.mem_we);
  assign bus.mem_rdata = (bus.mem_addr < 32'h100) ? dmem[bus.mem_addr[7:2]] : rom[bus.mem_addr[11:2]];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) dmem[i] <= dfill;
      wcnt <= 0;
    end else if (bus.mem_req) begin
      if (bus.mem_ready) begin
        wcnt  <= 0;
        n_acc <= n_acc + 1;
        if (bus.mem_we) begin
          dmem[bus.mem_addr[7:2]] <= bus.mem_wdata;
          n_wr <= n_wr + 1;
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  int n_cmp, n_fail;
  int rn, kend, stab_n, stab_err;
  int rk [0:31];
  logic [31:0] rpc [0:31];

  function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    rom[addr[11:2]] = word;
  endtask

  task automatic begin_reset();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 1024; i++) rom[i] = 32'hFC00_0000;
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Samples 1ns after each edge; sample k lies in cycle k after reset release.
  task automatic run_prog(input int budget);
    int k;
    bit prev_ret, prev_wait, pwe;
    logic [31:0] pa, pw;
    rn = 0; stab_n = 0; stab_err = 0; prev_ret = 0; prev_wait = 0;
    pa = '0; pw = '0; pwe = 0;
    #1;
    k = 1;
    while (k <= budget) begin
      if (prev_ret && rn > 0) rpc[rn-1] = pc;
      if (prev_wait) begin
        stab_n++;
        if (!(bus.mem_req === 1'b1 && bus.mem_addr === pa && bus.mem_we === pwe && bus.mem_wdata === pw))
          stab_err++;
      end
      if (halted === 1'b1) break;
      if (retire === 1'b1 && rn < 32) begin rk[rn] = k; rn++; end
      prev_ret  = retire;
      prev_wait = bus.mem_req && !bus.mem_ready;
      pa = bus.mem_addr; pw = bus.mem_wdata; pwe = bus.mem_we;
      @(posedge clk); #1;
      k++;
    end
    kend = k;
    n_cmp++;
    if (k > budget) begin n_fail++; $display("FAIL run_timeout: cycles %0d budget %0d", k, budget); end
  endtask

  task automatic test_reset();
    begin_reset();
    @(negedge clk); @(negedge clk);
    n_cmp++; if (pc !== 32'h100) begin n_fail++; $display("FAIL rst_pc: got %h want %h", pc, 32'h100); end
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", bus.mem_req); end
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", bus.mem_we); end
    n_cmp++; if (bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL rst_addr: got %h want %h", bus.mem_addr, 32'h100); end
    n_cmp++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", bus.mem_wdata); end
    n_cmp++; if (retire !== 1'b0) begin n_fail++; $display("FAIL rst_retire: got %b want 0", retire); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b want 0", halted); end
  endtask

  task automatic load_basic();
    put(32'h100, ei(6'h08, 0, 1, 16'd5));
    put(32'h104, ei(6'h08, 0, 2, 16'hFFFD));
    put(32'h108, er(1, 2, 3, 0, 6'h20));
    put(32'h10C, ei(6'h2B, 0, 3, 16'h0040));
    put(32'h110, ei(6'h23, 0, 4, 16'h0040));
    put(32'h114, ei(6'h2B, 0, 4, 16'h0044));
  endtask

  task automatic test_basic();
    begin_reset();
    dfill = 32'h0; wait_n = 0;
    load_basic();
    release_reset();
    run_prog(200);
    n_cmp++; if (rk[0] !== 4) begin n_fail++; $display("FAIL basic_first_retire: got %0d want 4", rk[0]); end
    n_cmp++; if (rk[4] !== 21) begin n_fail++; $display("FAIL basic_cycles: got %0d want 21", rk[4]); end
    n_cmp++; if (rn !== 6) begin n_fail++; $display("FAIL basic_retires: got %0d want 6", rn); end
    n_cmp++; if (dmem[16] !== 32'd2) begin n_fail++; $display("FAIL basic_mem40: got %h want 2", dmem[16]); end
    n_cmp++; if (dmem[17] !== 32'd2) begin n_fail++; $display("FAIL basic_r4: got %h want 2", dmem[17]); end
  endtask

  task automatic test_branches();
    begin_reset();
    dfill = 32'h0; wait_n = 0;
    put(32'h100, ei(6'h04, 0, 0, 16'd2));
    put(32'h10C, ei(6'h08, 0, 1, 16'd7));
    put(32'h110, ei(6'h05, 1, 1, 16'd2));
    put(32'h114, ei(6'h0D, 0, 5, 16'hFFFF));
    put(32'h118, ei(6'h2B, 0, 5, 16'h0048));
    put(32'h11C, {6'h02, 26'h000_0100});
    put(32'h400, ei(6'h05, 1, 0, 16'd1));
    put(32'h408, ei(6'h2B, 0, 1, 16'h004C));
    release_reset();
    run_prog(200);
    n_cmp++; if (rk[0] !== 3) begin n_fail++; $display("FAIL br_cycles: got %0d want 3", rk[0]); end
    n_cmp++; if (rpc[0] !== 32'h10C) begin n_fail++; $display("FAIL br_beq_pc: got %h want %h", rpc[0], 32'h10C); end
    n_cmp++; if (rpc[2] !== 32'h114) begin n_fail++; $display("FAIL br_bne_nt_pc: got %h want %h", rpc[2], 32'h114); end
    n_cmp++; if (rpc[5] !== 32'h400) begin n_fail++; $display("FAIL br_j_pc: got %h want %h", rpc[5], 32'h400); end
    n_cmp++; if (rpc[6] !== 32'h408) begin n_fail++; $display("FAIL br_bne_t_pc: got %h want %h", rpc[6], 32'h408); end
    n_cmp++; if (dmem[18] !== 32'h0000_FFFF) begin n_fail++; $display("FAIL br_ori: got %h want %h", dmem[18], 32'h0000_FFFF); end
    n_cmp++; if (dmem[19] !== 32'd7) begin n_fail++; $display("FAIL br_r1: got %h want 7", dmem[19]); end
    n_cmp++; if (rn !== 8) begin n_fail++; $display("FAIL br_retires: got %0d want 8", rn); end
  endtask

  task automatic test_wait_states();
    begin_reset();
    dfill = 32'h0; wait_n = 3;
    load_basic();
    release_reset();
    run_prog(400);
    n_cmp++; if (rk[4] - rk[3] !== 11) begin n_fail++; $display("FAIL ws_lw_cycles: got %0d want 11", rk[4] - rk[3]); end
    n_cmp++; if (rk[4] !== 42) begin n_fail++; $display("FAIL ws_total: got %0d want 42", rk[4]); end
    n_cmp++; if (stab_n == 0 || stab_err != 0) begin
      n_fail++; $display("FAIL ws_stable: waits %0d unstable %0d want >0 and 0", stab_n, stab_err);
    end
    n_cmp++; if (dmem[17] !== 32'd2) begin n_fail++; $display("FAIL ws_r4: got %h want 2", dmem[17]); end
    wait_n = 0;
  endtask

  task automatic test_faults();
    int bad, a0;
    begin_reset();
    dfill = 32'h0; wait_n = 0;
    release_reset();
    run_prog(50);
    n_cmp++; if (kend !== 3) begin n_fail++; $display("FAIL ill_halt_cycle: got %0d want 3", kend); end
    n_cmp++; if (pc !== 32'h104) begin n_fail++; $display("FAIL ill_pc: got %h want %h", pc, 32'h104); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    n_cmp++; if (bad != 0 || rn != 0) begin n_fail++; $display("FAIL ill_quiet: bad cycles %0d retires %0d want 0 0", bad, rn); end

    begin_reset();
    put(32'h100, ei(6'h08, 0, 9, 16'd77));
    put(32'h104, ei(6'h23, 0, 9, 16'h0042));
    a0 = n_acc;
    release_reset();
    run_prog(50);
    n_cmp++; if (kend !== 8) begin n_fail++; $display("FAIL mis_halt_cycle: got %0d want 8", kend); end
    n_cmp++; if (pc !== 32'h108) begin n_fail++; $display("FAIL mis_pc: got %h want %h", pc, 32'h108); end
    n_cmp++; if (dut.r_rf[9] !== 32'd77) begin n_fail++; $display("FAIL mis_rt: got %h want %h", dut.r_rf[9], 32'd77); end
    n_cmp++; if (n_acc - a0 !== 2) begin n_fail++; $display("FAIL mis_accesses: got %0d want 2", n_acc - a0); end
    reset = 1'b0; #1;
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_cleared: got %b want 0", halted); end
  endtask

  task automatic test_reset_mid_sw();
    int w0, n;
    begin_reset();
    dfill = 32'h5A5A_5A5A; wait_n = 0; hold_wr = 1;
    put(32'h100, ei(6'h08, 0, 1, 16'd9));
    put(32'h104, ei(6'h2B, 0, 1, 16'h0050));
    release_reset();
    n = 0;
    while (bus.mem_we !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    n_cmp++; if (n >= 40) begin n_fail++; $display("FAIL msw_reach: cycles %0d limit 40", n); end
    w0 = n_wr;
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h50 || bus.mem_wdata !== 32'd9) begin
      n_fail++; $display("FAIL msw_stall: req %b addr %h data %h want 1 50 9", bus.mem_req, bus.mem_addr, bus.mem_wdata);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL msw_req_drop: got %b want 0", bus.mem_req); end
    n_cmp++; if (pc !== 32'h100) begin n_fail++; $display("FAIL msw_pc: got %h want %h", pc, 32'h100); end
    repeat (2) @(posedge clk);
    n_cmp++; if (n_wr !== w0) begin n_fail++; $display("FAIL msw_nowrite: got %0d writes want %0d", n_wr, w0); end
    hold_wr = 0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h100) begin
      n_fail++; $display("FAIL msw_refetch: req %b we %b addr %h want 1 0 100", bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    run_prog(100);
    n_cmp++; if (dmem[20] !== 32'd9) begin n_fail++; $display("FAIL msw_rerun: got %h want 9", dmem[20]); end
  endtask

  task automatic test_zero_shift();
    begin_reset();
    dfill = 32'hA5A5_A5A5; wait_n = 0;
    put(32'h100, ei(6'h08, 0, 1, 16'd5));
    put(32'h104, ei(6'h08, 0, 2, 16'hFFFD));
    put(32'h108, er(1, 1, 0, 0, 6'h20));
    put(32'h10C, ei(6'h2B, 0, 0, 16'h0060));
    put(32'h110, er(0, 1, 6, 5'd4, 6'h00));
    put(32'h114, ei(6'h2B, 0, 6, 16'h0064));
    put(32'h118, er(0, 2, 7, 5'd28, 6'h02));
    put(32'h11C, ei(6'h2B, 0, 7, 16'h0068));
    put(32'h120, er(2, 1, 8, 0, 6'h2A));
    put(32'h124, ei(6'h2B, 0, 8, 16'h006C));
    put(32'h128, er(1, 1, 9, 0, 6'h3F));
    release_reset();
    run_prog(300);
    n_cmp++; if (rk[2] !== 12) begin n_fail++; $display("FAIL z_retire: got %0d want 12", rk[2]); end
    n_cmp++; if (dmem[24] !== 32'h0) begin n_fail++; $display("FAIL z_r0: got %h want 0", dmem[24]); end
    n_cmp++; if (dmem[25] !== 32'h50) begin n_fail++; $display("FAIL z_sll: got %h want %h", dmem[25], 32'h50); end
    n_cmp++; if (dmem[26] !== 32'hF) begin n_fail++; $display("FAIL z_srl: got %h want %h", dmem[26], 32'hF); end
    n_cmp++; if (dmem[27] !== 32'd1) begin n_fail++; $display("FAIL z_slt: got %h want 1", dmem[27]); end
    n_cmp++; if (rn !== 10) begin n_fail++; $display("FAIL z_retires: got %0d want 10", rn); end
    n_cmp++; if (pc !== 32'h12C) begin n_fail++; $display("FAIL z_badfunct_pc: got %h want %h", pc, 32'h12C); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; n_acc = 0; n_wr = 0;
    reset = 1'b1; hold_wr = 0; wait_n = 0; dfill = '0;
    #2;
    test_reset();
    test_basic();
    test_branches();
    test_wait_states();
    test_faults();
    test_reset_mid_sw();
    test_zero_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
